// File: rtl/plot_queue_if.sv
// Plot-request and VGA-adapter bus for plot_queue.
//   master : renderer side; drives plot requests and clear pulses, observes status and adapter port
//   slave  : plot_queue side; accepts requests, reports status, drives the adapter write port
// Signals:
//   in_valid/in_ready/in_x/in_y/in_colour : plot request handshake
//   clear_req/clear_colour                : full-screen clear request
//   busy/count/clip_err                   : status
//   vga_x/vga_y/vga_colour/vga_write      : adapter pixel write port
interface plot_queue_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_x;
    logic [6:0]        in_y;
    logic [2:0]        in_colour;
    logic              clear_req;
    logic [2:0]        clear_colour;
    logic              busy;
    logic [ADDR_W:0]   count;
    logic              clip_err;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_write;

    modport master (
        output in_valid, in_x, in_y, in_colour, clear_req, clear_colour,
        input  in_ready, busy, count, clip_err, vga_x, vga_y, vga_colour, vga_write
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, clear_req, clear_colour,
        output in_ready, busy, count, clip_err, vga_x, vga_y, vga_colour, vga_write
    );
endinterface

// File: rtl/plot_queue.sv
// Pixel-write responder between the renderer and the VGA adapter.
// Buffers plot requests in a FIFO, drains them to the adapter at one pixel
// per cycle, clips off-screen requests, and runs a hardware full-screen clear.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : plot_queue_if.slave (request handshake, clear request, status, adapter port)
module plot_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        reset,
    plot_queue_if.slave bus
);
    localparam int unsigned   CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [7:0]    X_LIM   = 8'(SCREEN_W);
    localparam logic [6:0]    Y_LIM   = 7'(SCREEN_H);
    localparam logic [7:0]    X_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0]    Y_LAST  = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    pixel_t             mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   count;
    state_t             state;
    logic [7:0]         cx;
    logic [6:0]         cy;
    logic [2:0]         fill_colour;
    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_write;
    logic               clip_err;

    logic               ready;
    logic               xfer;
    logic               in_range;
    logic               push;
    logic               pop;

    // Handshake depends on registered state only, never on in_valid.
    assign ready    = (state == IDLE) && (count < DEPTH_C) && !reset;
    assign xfer     = bus.in_valid && ready;
    assign in_range = (bus.in_x < X_LIM) && (bus.in_y < Y_LIM);
    assign push     = xfer && in_range;
    // The FIFO only drains outside a clear; CLEAR owns the adapter port.
    assign pop      = ((state == IDLE) || (state == DRAIN)) && (count != '0);

    assign bus.in_ready   = ready;
    assign bus.count      = count;
    assign bus.clip_err   = clip_err;
    assign bus.vga_x      = vga_x;
    assign bus.vga_y      = vga_y;
    assign bus.vga_colour = vga_colour;
    assign bus.vga_write  = vga_write;
    assign bus.busy       = (count != '0) || (state != IDLE) || vga_write;

    // FIFO storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{x: bus.in_x, y: bus.in_y, colour: bus.in_colour};
        end
    end

    // Pointers, occupancy, sequencing and the registered adapter port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            fill_colour <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_write   <= 1'b0;
            clip_err    <= 1'b0;
        end else begin
            vga_write <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            if (pop) begin
                rd_ptr     <= rd_ptr + ADDR_W'(1);
                vga_x      <= mem[rd_ptr].x;
                vga_y      <= mem[rd_ptr].y;
                vga_colour <= mem[rd_ptr].colour;
                vga_write  <= 1'b1;
            end

            // Simultaneous push and pop leaves the occupancy unchanged.
            count <= count + CNT_W'(push) - CNT_W'(pop);

            // Off-screen requests are consumed but dropped, and flagged until reset.
            if (xfer && !in_range) begin
                clip_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        fill_colour <= bus.clear_colour;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Queued pixels land before the clear so the clear wins visually.
                    if (count == '0) begin
                        cx    <= '0;
                        cy    <= '0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= fill_colour;
                    vga_write  <= 1'b1;
                    // Raster order: x fastest, y on x wrap; the last pixel ends the clear.
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            state <= IDLE;
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plot_queue.sv
// Self-checking bench for plot_queue: directed steps with randomized pixel
// data, compared every cycle against a queue-based reference model.
module tb_plot_queue;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int CLEAR_PIX = SCREEN_W * SCREEN_H;

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    plot_queue_if #(.ADDR_W(ADDR_W)) bus ();

    plot_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of pending pixels plus a mode and a clear index.
    px_t m_fifo[$];
    int  m_mode;       // 0 idle, 1 waiting for queue to empty, 2 clearing
    int  m_k;          // next clear pixel index in raster order
    int  m_clr;
    int  m_x, m_y, m_c;
    bit  m_write;
    bit  m_clip;
    int  m_clear_idx;  // clear pixel emitted by the last edge, or -1
    int  obs_writes = 0;
    int  exp_writes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_mode      = 0;
        m_k         = 0;
        m_clr       = 0;
        m_x         = 0;
        m_y         = 0;
        m_c         = 0;
        m_write     = 1'b0;
        m_clip      = 1'b0;
        m_clear_idx = -1;
    endtask

    // Advance one clock with the currently driven inputs and check every output.
    task automatic cycle();
        int   size0;
        px_t  p;
        bit   exp_ready;
        bit   acc;
        #1;
        exp_ready = (m_mode == 0) && (m_fifo.size() < int'(DEPTH));
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        acc         = (bus.in_valid === 1'b1) && exp_ready;
        size0       = m_fifo.size();
        m_write     = 1'b0;
        m_clear_idx = -1;
        if (m_mode != 2 && size0 > 0) begin
            p       = m_fifo.pop_front();
            m_x     = p.x;
            m_y     = p.y;
            m_c     = p.c;
            m_write = 1'b1;
        end
        if (m_mode == 2) begin
            m_x         = m_k % SCREEN_W;
            m_y         = m_k / SCREEN_W;
            m_c         = m_clr;
            m_write     = 1'b1;
            m_clear_idx = m_k;
            m_k++;
            if (m_k == CLEAR_PIX) m_mode = 0;
        end else if (m_mode == 1) begin
            if (size0 == 0) begin
                m_mode = 2;
                m_k    = 0;
            end
        end else if (bus.clear_req === 1'b1) begin
            m_mode = 1;
            m_clr  = int'(bus.clear_colour);
        end
        if (acc) begin
            if (int'(bus.in_x) < SCREEN_W && int'(bus.in_y) < SCREEN_H) begin
                p.x = int'(bus.in_x);
                p.y = int'(bus.in_y);
                p.c = int'(bus.in_colour);
                m_fifo.push_back(p);
            end else begin
                m_clip = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        if (bus.vga_write === 1'b1) obs_writes++;
        if (m_write) exp_writes++;
        chk("vga_write", {31'd0, bus.vga_write}, {31'd0, m_write});
        chk("vga_x", {24'd0, bus.vga_x}, m_x);
        chk("vga_y", {25'd0, bus.vga_y}, m_y);
        chk("vga_colour", {29'd0, bus.vga_colour}, m_c);
        chk("count", {27'd0, bus.count}, m_fifo.size());
        chk("busy", {31'd0, bus.busy},
            {31'd0, (m_fifo.size() != 0) || (m_mode != 0) || m_write});
        chk("clip_err", {31'd0, bus.clip_err}, {31'd0, m_clip});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_write", {31'd0, bus.vga_write}, 0);
        chk("rst_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_count", {27'd0, bus.count}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_clip", {31'd0, bus.clip_err}, 0);
        chk("rst_x", {24'd0, bus.vga_x}, 0);
        chk("rst_y", {25'd0, bus.vga_y}, 0);
        chk("rst_colour", {29'd0, bus.vga_colour}, 0);
        model_reset();
        @(posedge clock);
        #1;
        chk("rst_hold_write", {31'd0, bus.vga_write}, 0);
        reset = 1'b0;
    endtask

    task automatic run_idle(input string tag);
        int guard = 0;
        while ((m_mode != 0 || m_fifo.size() != 0 || m_write) && guard < 30000) begin
            cycle();
            guard++;
        end
        chk(tag, {31'd0, guard < 30000}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  guard;
        int  obs_base;
        bit  acc;

        bus.in_valid     = 1'b0;
        bus.in_x         = '0;
        bus.in_y         = '0;
        bus.in_colour    = '0;
        bus.clear_req    = 1'b0;
        bus.clear_colour = '0;
        model_reset();
        #2;
        do_reset();

        // Single pixel: strobe two edges after the push, for exactly one cycle.
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'd10;
        bus.in_y      = 7'd20;
        bus.in_colour = 3'b101;
        cycle();
        bus.in_valid = 1'b0;
        chk("lat_edge1_write", {31'd0, bus.vga_write}, 0);
        chk("lat_edge1_count", {27'd0, bus.count}, 1);
        cycle();
        chk("lat_edge2_write", {31'd0, bus.vga_write}, 1);
        chk("lat_edge2_x", {24'd0, bus.vga_x}, 10);
        chk("lat_edge2_y", {25'd0, bus.vga_y}, 20);
        chk("lat_edge2_colour", {29'd0, bus.vga_colour}, 5);
        chk("lat_edge2_busy", {31'd0, bus.busy}, 1);
        cycle();
        chk("lat_edge3_write", {31'd0, bus.vga_write}, 0);
        chk("lat_edge3_count", {27'd0, bus.count}, 0);
        chk("lat_edge3_busy", {31'd0, bus.busy}, 0);

        // Stream of 20 distinct pixels with random valid gaps.
        n     = 0;
        guard = 0;
        bus.in_x      = 8'd1;
        bus.in_y      = 7'($urandom_range(0, SCREEN_H - 1));
        bus.in_colour = 3'($urandom_range(0, 7));
        while (n < 20 && guard < 500) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            cycle();
            if (acc) begin
                n++;
                bus.in_x      = 8'(n * 7 + 1);
                bus.in_y      = 7'($urandom_range(0, SCREEN_H - 1));
                bus.in_colour = 3'($urandom_range(0, 7));
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("stream_accepted", n, 20);
        run_idle("stream_idle");
        cycle();
        chk("stream_writes", obs_writes, 21);
        chk("stream_model_writes", obs_writes, exp_writes);

        // Off-screen requests are accepted but never written.
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'd160;
        bus.in_y      = 7'd5;
        bus.in_colour = 3'd1;
        chk("clip_ready_x", {31'd0, bus.in_ready}, 1);
        cycle();
        bus.in_x      = 8'd3;
        bus.in_y      = 7'd120;
        bus.in_colour = 3'd2;
        chk("clip_ready_y", {31'd0, bus.in_ready}, 1);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        chk("clip_flag", {31'd0, bus.clip_err}, 1);
        chk("clip_no_write", obs_writes, 21);

        // Three queued pixels, then a clear; a second clear mid-way is ignored.
        obs_base = obs_writes;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_x      = 8'(i * 50 + 5);
            bus.in_y      = 7'(i * 30 + 2);
            bus.in_colour = 3'(i + 1);
            if (i == 2) begin
                bus.clear_req    = 1'b1;
                bus.clear_colour = 3'b010;
            end
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.clear_req = 1'b0;
        guard = 0;
        while ((m_mode != 0 || m_fifo.size() != 0 || m_write) && guard < 25000) begin
            bus.clear_req    = (m_clear_idx == 100);
            bus.clear_colour = 3'b111;
            bus.in_valid     = (m_clear_idx >= 10 && m_clear_idx <= 200);
            bus.in_x         = 8'd50;
            bus.in_y         = 7'd60;
            bus.in_colour    = 3'd7;
            cycle();
            if (m_clear_idx == 0) begin
                chk("clear_first_x", {24'd0, bus.vga_x}, 0);
                chk("clear_first_y", {25'd0, bus.vga_y}, 0);
                chk("clear_first_colour", {29'd0, bus.vga_colour}, 2);
            end
            if (m_clear_idx == CLEAR_PIX - 1) begin
                chk("clear_last_x", {24'd0, bus.vga_x}, 159);
                chk("clear_last_y", {25'd0, bus.vga_y}, 119);
                chk("clear_last_colour", {29'd0, bus.vga_colour}, 2);
            end
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.clear_req = 1'b0;
        chk("clear_finished", {31'd0, guard < 25000}, 1);
        cycle();
        chk("clear_total_writes", obs_writes - obs_base, 3 + CLEAR_PIX);
        chk("clear_busy_low", {31'd0, bus.busy}, 0);
        chk("clear_clip_sticky", {31'd0, bus.clip_err}, 1);

        // Reset in the middle of a clear abandons it.
        bus.clear_colour = 3'b001;
        bus.clear_req    = 1'b1;
        cycle();
        bus.clear_req = 1'b0;
        guard = 0;
        while (m_clear_idx != 5000 && guard < 25000) begin
            cycle();
            guard++;
        end
        chk("abort_reached", m_clear_idx, 5000);
        chk("abort_pre_write", {31'd0, bus.vga_write}, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        chk("abort_quiet_busy", {31'd0, bus.busy}, 0);
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'd77;
        bus.in_y      = 7'd33;
        bus.in_colour = 3'd6;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        chk("post_rst_write", {31'd0, bus.vga_write}, 1);
        chk("post_rst_x", {24'd0, bus.vga_x}, 77);
        chk("post_rst_y", {25'd0, bus.vga_y}, 33);
        chk("post_rst_colour", {29'd0, bus.vga_colour}, 6);
        run_idle("post_rst_idle");
        cycle();
        chk("final_model_writes", obs_writes, exp_writes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
